// File: rtl/fib_pkg.sv
// Shared types and constants for the Fibonacci sequencer slice.
package fib_pkg;

  localparam int unsigned DEF_WIDTH = 4;
  localparam int unsigned DEF_NW    = 4;

  localparam int unsigned INIT_A = 0;
  localparam int unsigned INIT_B = 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/fib_datapath.sv
// Fibonacci add-and-shift datapath: a holds F(k), b holds F(k+1), each mod 2^WIDTH,
// with sticky overflow tracking for both registers.
module fib_datapath
  import fib_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             init,
  input  logic             step,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             ovf_a
);

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             ovf_a_q, ovf_a_d;
  logic             ovf_b_q, ovf_b_d;
  logic [WIDTH:0]   sum;

  always_comb begin
    sum     = {1'b0, a_q} + {1'b0, b_q};
    a_d     = a_q;
    b_d     = b_q;
    ovf_a_d = ovf_a_q;
    ovf_b_d = ovf_b_q;
    if (init) begin
      a_d     = WIDTH'(INIT_A);
      b_d     = WIDTH'(INIT_B);
      ovf_a_d = 1'b0;
      ovf_b_d = 1'b0;
    end else if (step) begin
      a_d     = b_q;
      b_d     = sum[WIDTH-1:0];
      ovf_a_d = ovf_b_q;
      // b inherits any earlier overflow: true F(k+2) >= F(k+1) >= F(k)
      ovf_b_d = sum[WIDTH] | ovf_a_q | ovf_b_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_q     <= '0;
      b_q     <= '0;
      ovf_a_q <= 1'b0;
      ovf_b_q <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      ovf_a_q <= ovf_a_d;
      ovf_b_q <= ovf_b_d;
    end
  end

  assign a     = a_q;
  assign b     = b_q;
  assign ovf_a = ovf_a_q;

endmodule

// File: rtl/fib_sequencer.sv
// Start/done controller that runs the Fibonacci datapath n steps and returns F(n)
// with an exact overflow flag, streaming each intermediate term.
module fib_sequencer
  import fib_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned NW    = DEF_NW
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [NW-1:0]    n,
  output logic             busy,
  output logic             term_valid,
  output logic [WIDTH-1:0] term,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             overflow
);

  state_e           state_q, state_d;
  logic [NW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             overflow_q, overflow_d;

  logic             dp_init;
  logic             dp_step;
  logic [WIDTH-1:0] dp_a;
  logic [WIDTH-1:0] dp_b;
  logic             dp_ovf_a;

  fib_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clock (clock),
    .reset (reset),
    .init  (dp_init),
    .step  (dp_step),
    .a     (dp_a),
    .b     (dp_b),
    .ovf_a (dp_ovf_a)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    result_d   = result_q;
    overflow_d = overflow_q;
    dp_init    = 1'b0;
    dp_step    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = n;
          dp_init = 1'b1;
        end
      end
      RUN: begin
        if (cnt_q != '0) begin
          dp_step = 1'b1;
          cnt_d   = cnt_q - 1'b1;
        end else begin
          result_d   = dp_a;
          overflow_d = dp_ovf_a;
          done_d     = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      result_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
    end
  end

  assign busy       = (state_q == RUN);
  assign term_valid = (state_q == RUN) && (cnt_q != '0);
  assign term       = dp_a;
  assign done       = done_q;
  assign result     = result_q;
  assign overflow   = overflow_q;

  // Shift half of the datapath: every step moves b into a.
  a_follows_b : assert property (@(posedge clock) disable iff (reset)
    dp_step |=> (dp_a == $past(dp_b)));

endmodule
